// File: rtl/cla_chunk_adder.sv
// Multi-cycle adder/subtractor: one CHUNK-bit carry-lookahead slice per clock, LSB slice first.
// Results, carry-out and signed overflow update only on the edge that raises done.
module cla_chunk_adder #(
    parameter int unsigned WIDTH = 24,
    parameter int unsigned CHUNK = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] so,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned NCHUNK = WIDTH / CHUNK;
    localparam int unsigned CNTW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [CNTW-1:0] LAST_CNT = CNTW'(NCHUNK - 1);

    if ((CHUNK == 0) || (WIDTH == 0) || ((WIDTH % CHUNK) != 0)) begin : g_param_check
        $error("WIDTH must be a positive multiple of CHUNK");
    end

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state_q, state_d;
    logic [CNTW-1:0]  cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] so_q, so_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             done_q, done_d;

    logic [31:0]      base;
    logic [CHUNK-1:0] sa, sb, sg, sp, ssum;
    logic [CHUNK:0]   sc;
    logic             term;
    logic             last, accept;

    // Slice adder: every carry is a flat sum-of-products of g/p and the slice carry-in.
    always_comb begin
        base = 32'(cnt_q) * CHUNK;
        sa   = a_q[base +: CHUNK];
        sb   = b_q[base +: CHUNK];
        sg   = sa & sb;
        sp   = sa ^ sb;
        sc   = '0;
        term = 1'b0;
        sc[0] = carry_q;
        for (int i = 0; i < int'(CHUNK); i++) begin
            sc[i+1] = sg[i];
            term    = sp[i];
            for (int j = i - 1; j >= 0; j--) begin
                sc[i+1] = sc[i+1] | (term & sg[j]);
                term    = term & sp[j];
            end
            sc[i+1] = sc[i+1] | (term & sc[0]);
        end
        ssum = sp ^ sc[CHUNK-1:0];
    end

    assign last   = (state_q == StRun) && (cnt_q == LAST_CNT);
    // A start on the completing edge is taken so back-to-back operations run at full rate.
    assign accept = start && ((state_q != StRun) || last);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        so_d    = so_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        done_d  = 1'b0;

        case (state_q)
            StRun: begin
                acc_d[base +: CHUNK] = ssum;
                carry_d = sc[CHUNK];
                cnt_d   = cnt_q + CNTW'(1);
                if (last) begin
                    so_d    = acc_d;
                    cout_d  = sc[CHUNK];
                    ovf_d   = sc[CHUNK] ^ sc[CHUNK-1];
                    done_d  = 1'b1;
                    state_d = StDone;
                end
            end
            StDone: begin
                if (!start) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Subtraction is A + ~B + ~borrow; inversion happens once, at capture.
        if (accept) begin
            a_d     = a;
            b_d     = sub ? ~b : b;
            carry_d = cin ^ sub;
            cnt_d   = '0;
            state_d = StRun;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            so_q    <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            so_q    <= so_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
        end
    end

    assign busy = (state_q == StRun);
    assign done = done_q;
    assign so   = so_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_cla_chunk_adder.sv
// Directed bench: a 24-bit/6-bit-chunk instance and a single-chunk 6-bit instance.
module tb_cla_chunk_adder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        start, sub, cin;
    logic [23:0] a, b;
    logic        busy, done, cout, ovf;
    logic [23:0] so;

    logic        start6, sub6, cin6;
    logic [5:0]  a6, b6;
    logic        busy6, done6, cout6, ovf6;
    logic [5:0]  so6;

    int passed = 0;
    int total  = 0;

    cla_chunk_adder #(.WIDTH(24), .CHUNK(6)) dut24 (
        .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .a(a), .b(b), .cin(cin),
        .busy(busy), .done(done), .so(so), .cout(cout), .ovf(ovf)
    );

    cla_chunk_adder #(.WIDTH(6), .CHUNK(6)) dut6 (
        .clk(clk), .rst_n(rst_n), .start(start6), .sub(sub6), .a(a6), .b(b6), .cin(cin6),
        .busy(busy6), .done(done6), .so(so6), .cout(cout6), .ovf(ovf6)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one operation for a single edge (E0); returns at E0+1ns.
    task automatic issue(input logic [23:0] ia, input logic [23:0] ib, input logic ic,
                         input logic isub);
        a = ia; b = ib; cin = ic; sub = isub; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Returns the edge offset from E0 at which done was seen (20 on timeout).
    task automatic wait_done(output int cyc);
        cyc = 1;
        tick();
        while (!done && cyc < 20) begin
            tick();
            cyc++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        total++; if ({busy, done, cout, ovf} !== 4'b0) $display("FAIL reset_flags: got %b want 0000", {busy, done, cout, ovf}); else passed++;
        total++; if (so !== 24'h0) $display("FAIL reset_so: got %h want 000000", so); else passed++;
        total++; if ({busy6, done6, so6} !== 8'h0) $display("FAIL reset_dut6: got %h want 00", {busy6, done6, so6}); else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_add_wrap();
        issue(24'hFFFFFF, 24'h000001, 1'b0, 1'b0);
        total++; if ({busy, done} !== 2'b10) $display("FAIL wrap_e0: busy/done got %b want 10", {busy, done}); else passed++;
        for (int k = 1; k < 4; k++) begin
            tick();
            total++; if ({busy, done} !== 2'b10) $display("FAIL wrap_run%0d: busy/done got %b want 10", k, {busy, done}); else passed++;
        end
        tick();
        total++; if ({busy, done} !== 2'b01) $display("FAIL wrap_e4: busy/done got %b want 01", {busy, done}); else passed++;
        total++; if ({so, cout, ovf} !== {24'h000000, 2'b10}) $display("FAIL wrap_result: got %h %b%b want 000000 10", so, cout, ovf); else passed++;
        tick();
        total++; if ({busy, done} !== 2'b00) $display("FAIL wrap_e5: busy/done got %b want 00", {busy, done}); else passed++;
        total++; if (so !== 24'h000000 || cout !== 1'b1) $display("FAIL wrap_hold: got %h %b want 000000 1", so, cout); else passed++;
    endtask

    task automatic test_carry_chain();
        issue(24'h7FFFFF, 24'h000001, 1'b0, 1'b0);
        for (int k = 1; k < 4; k++) begin
            tick();
            total++; if (dut24.carry_q !== 1'b1) $display("FAIL chain_carry%0d: got %b want 1", k, dut24.carry_q); else passed++;
            total++; if (done !== 1'b0) $display("FAIL chain_early%0d: done got %b want 0", k, done); else passed++;
        end
        tick();
        total++; if (done !== 1'b1) $display("FAIL chain_done: got %b want 1", done); else passed++;
        total++; if ({so, cout, ovf} !== {24'h800000, 2'b01}) $display("FAIL chain_result: got %h %b%b want 800000 01", so, cout, ovf); else passed++;
    endtask

    task automatic test_sub();
        int cyc;
        issue(24'h000005, 24'h000007, 1'b0, 1'b1);
        wait_done(cyc);
        total++; if (cyc !== 4) $display("FAIL sub1_latency: got %0d want 4", cyc); else passed++;
        total++; if ({so, cout, ovf} !== {24'hFFFFFE, 2'b00}) $display("FAIL sub1_result: got %h %b%b want fffffe 00", so, cout, ovf); else passed++;
        tick();
        issue(24'h800000, 24'h000001, 1'b0, 1'b1);
        wait_done(cyc);
        total++; if (cyc !== 4) $display("FAIL sub2_latency: got %0d want 4", cyc); else passed++;
        total++; if ({so, cout, ovf} !== {24'h7FFFFF, 2'b11}) $display("FAIL sub2_result: got %h %b%b want 7fffff 11", so, cout, ovf); else passed++;
        tick();
    endtask

    task automatic test_busy_ignore();
        int ndone;
        int first_at;
        logic [23:0] first_so;
        ndone = 0; first_at = 0; first_so = 24'h0;
        issue(24'h000001, 24'h000002, 1'b0, 1'b0);
        tick();
        a = 24'h111111; b = 24'h222222; start = 1'b1;
        tick();
        start = 1'b0;
        total++; if (busy !== 1'b1) $display("FAIL ignore_busy: got %b want 1", busy); else passed++;
        for (int k = 3; k < 12; k++) begin
            tick();
            if (done) begin
                ndone++;
                if (ndone == 1) begin
                    first_at = k;
                    first_so = so;
                end
            end
        end
        total++; if (ndone !== 1) $display("FAIL ignore_count: done pulses got %0d want 1", ndone); else passed++;
        total++; if (first_at !== 4) $display("FAIL ignore_edge: got E0+%0d want E0+4", first_at); else passed++;
        total++; if (first_so !== 24'h000003) $display("FAIL ignore_result: got %h want 000003", first_so); else passed++;
    endtask

    task automatic test_reset_mid();
        int ndone;
        int cyc;
        ndone = 0;
        issue(24'h123456, 24'h000001, 1'b0, 1'b0);
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        total++; if ({busy, done, cout, ovf} !== 4'b0) $display("FAIL midrst_flags: got %b want 0000", {busy, done, cout, ovf}); else passed++;
        total++; if (so !== 24'h0) $display("FAIL midrst_so: got %h want 000000", so); else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (done) ndone++;
        end
        total++; if (ndone !== 0) $display("FAIL midrst_nodone: got %0d want 0", ndone); else passed++;
        total++; if (so !== 24'h0) $display("FAIL midrst_hold: got %h want 000000", so); else passed++;
        issue(24'h000010, 24'h000020, 1'b0, 1'b0);
        wait_done(cyc);
        total++; if (cyc !== 4) $display("FAIL midrst_latency: got %0d want 4", cyc); else passed++;
        total++; if ({so, cout, ovf} !== {24'h000030, 2'b00}) $display("FAIL midrst_result: got %h %b%b want 000030 00", so, cout, ovf); else passed++;
        tick();
    endtask

    task automatic test_back_to_back();
        issue(24'h000100, 24'h000200, 1'b0, 1'b0);
        tick();
        tick();
        tick();
        a = 24'h0A0000; b = 24'h050000; sub = 1'b1; cin = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        total++; if ({busy, done} !== 2'b11) $display("FAIL b2b_overlap: busy/done got %b want 11", {busy, done}); else passed++;
        total++; if (so !== 24'h000300) $display("FAIL b2b_first: got %h want 000300", so); else passed++;
        for (int k = 5; k < 8; k++) begin
            tick();
            total++; if ({busy, done} !== 2'b10) $display("FAIL b2b_run%0d: busy/done got %b want 10", k, {busy, done}); else passed++;
        end
        tick();
        total++; if ({busy, done} !== 2'b01) $display("FAIL b2b_done2: busy/done got %b want 01", {busy, done}); else passed++;
        total++; if ({so, cout, ovf} !== {24'h050000, 2'b10}) $display("FAIL b2b_second: got %h %b%b want 050000 10", so, cout, ovf); else passed++;
        tick();
    endtask

    task automatic test_single_chunk();
        a6 = 6'h3F; b6 = 6'h01; cin6 = 1'b1; sub6 = 1'b0; start6 = 1'b1;
        tick();
        start6 = 1'b0;
        total++; if ({busy6, done6} !== 2'b10) $display("FAIL one_e0: busy/done got %b want 10", {busy6, done6}); else passed++;
        tick();
        total++; if ({busy6, done6} !== 2'b01) $display("FAIL one_e1: busy/done got %b want 01", {busy6, done6}); else passed++;
        total++; if ({so6, cout6, ovf6} !== {6'h01, 2'b10}) $display("FAIL one_result: got %h %b%b want 01 10", so6, cout6, ovf6); else passed++;
        tick();
        total++; if (done6 !== 1'b0) $display("FAIL one_pulse: done got %b want 0", done6); else passed++;

        a6 = 6'h01; b6 = 6'h02; cin6 = 1'b0; start6 = 1'b1;
        tick();
        a6 = 6'h10; b6 = 6'h10;
        tick();
        total++; if ({busy6, done6} !== 2'b11) $display("FAIL one_b2b1_flags: got %b want 11", {busy6, done6}); else passed++;
        total++; if ({so6, cout6, ovf6} !== {6'h03, 2'b00}) $display("FAIL one_b2b1: got %h %b%b want 03 00", so6, cout6, ovf6); else passed++;
        a6 = 6'h20; b6 = 6'h20;
        tick();
        total++; if (done6 !== 1'b1) $display("FAIL one_b2b2_done: got %b want 1", done6); else passed++;
        total++; if ({so6, cout6, ovf6} !== {6'h20, 2'b01}) $display("FAIL one_b2b2: got %h %b%b want 20 01", so6, cout6, ovf6); else passed++;
        start6 = 1'b0;
        tick();
        total++; if ({busy6, done6} !== 2'b01) $display("FAIL one_b2b3_flags: got %b want 01", {busy6, done6}); else passed++;
        total++; if ({so6, cout6, ovf6} !== {6'h00, 2'b11}) $display("FAIL one_b2b3: got %h %b%b want 00 11", so6, cout6, ovf6); else passed++;
        tick();
        total++; if (done6 !== 1'b0) $display("FAIL one_end: done got %b want 0", done6); else passed++;
    endtask

    initial begin
        start = 1'b0; sub = 1'b0; cin = 1'b0; a = '0; b = '0;
        start6 = 1'b0; sub6 = 1'b0; cin6 = 1'b0; a6 = '0; b6 = '0;
        test_reset();
        test_add_wrap();
        test_carry_chain();
        test_sub();
        test_busy_ignore();
        test_reset_mid();
        test_back_to_back();
        test_single_chunk();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
